// File: rtl/line_buffer_ctrl_if.sv
// Signal bundle between the frame-timing source, the line shift RAM and the 3x3 matrix stage.
// The DUT side is the slave modport; the side that drives pixels and RAM taps is the master modport.
interface line_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  per_frame_vsync;
    logic                  per_frame_href;
    logic                  per_frame_clken;
    logic [DATA_WIDTH-1:0] per_img_data;
    logic                  ram_clken;
    logic [DATA_WIDTH-1:0] ram_shiftin;
    logic [DATA_WIDTH-1:0] ram_taps0x;
    logic [DATA_WIDTH-1:0] ram_taps1x;
    logic                  matrix_frame_vsync;
    logic                  matrix_frame_href;
    logic                  matrix_frame_clken;
    logic [DATA_WIDTH-1:0] matrix_row0;
    logic [DATA_WIDTH-1:0] matrix_row1;
    logic [DATA_WIDTH-1:0] matrix_row2;
    logic [10:0]           matrix_x;
    logic [10:0]           matrix_y;
    logic                  window_valid;
    logic                  line_err;

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
        input  ram_taps0x, ram_taps1x,
        output ram_clken, ram_shiftin,
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_row0, matrix_row1, matrix_row2, matrix_x, matrix_y,
        output window_valid, line_err
    );

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
        output ram_taps0x, ram_taps1x,
        input  ram_clken, ram_shiftin,
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_row0, matrix_row1, matrix_row2, matrix_x, matrix_y,
        input  window_valid, line_err
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line shift-RAM sequencer: gates RAM shifts per in-frame pixel, presents an aligned 3-row column, 1-cycle latency.
// No backpressure; excess pixels are dropped. Optional line-length checker: LINE_BUF_CTRL_LEN_CHECK_EN.
module line_buffer_ctrl #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    line_buffer_ctrl_if.slave bus
);
    localparam logic [10:0] HDISP = 11'(IMG_HDISP);
    localparam logic [10:0] VDISP = 11'(IMG_VDISP);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  vs_edge_q, href_q, mvs_q, mclk_q;
    logic [10:0]           x_q, x_d, y_q, y_d, mx_q, my_q;
    logic [DATA_WIDTH-1:0] row0_q, row1_q, row2_q;
    logic                  vs_rise, vs_fall, href_fall;
    logic                  in_line, accept, frame_start, line_end;

    assign vs_rise   = bus.per_frame_vsync & ~vs_edge_q;
    assign vs_fall   = ~bus.per_frame_vsync & vs_edge_q;
    assign href_fall = ~bus.per_frame_href & href_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (vs_fall) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (vs_rise) state_d = WAIT_LINE;
                WAIT_LINE: if (bus.per_frame_href) state_d = ACTIVE;
                ACTIVE:    if (href_fall) state_d = ((y_q + 11'd1) == VDISP) ? DONE : WAIT_LINE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_line     = (state_q == WAIT_LINE) || (state_q == ACTIVE);
        accept      = bus.per_frame_clken & bus.per_frame_href & bus.per_frame_vsync
                      & in_line & (x_q < HDISP);
        frame_start = (state_q == IDLE) & vs_rise;
        line_end    = (state_q == ACTIVE) & href_fall;
    end

    assign bus.ram_clken   = accept;
    assign bus.ram_shiftin = bus.per_img_data;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vs_fall || frame_start) begin
            x_d = '0;
            y_d = '0;
        end else if (line_end) begin
            x_d = '0;
            y_d = y_q + 11'd1;
        end else if (accept) begin
            x_d = x_q + 11'd1;
        end
    end

    // The edge register resets high so a reset taken mid-frame cannot see a fake vsync rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_edge_q <= 1'b1;
            href_q    <= 1'b0;
            mvs_q     <= 1'b0;
            mclk_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            row0_q    <= '0;
            row1_q    <= '0;
            row2_q    <= '0;
        end else begin
            vs_edge_q <= bus.per_frame_vsync;
            href_q    <= bus.per_frame_href;
            mvs_q     <= bus.per_frame_vsync;
            mclk_q    <= accept;
            x_q       <= x_d;
            y_q       <= y_d;
            if (accept) begin
                mx_q   <= x_q;
                my_q   <= y_q;
                row0_q <= bus.ram_taps1x;
                row1_q <= bus.ram_taps0x;
                row2_q <= bus.per_img_data;
            end
        end
    end

    assign bus.matrix_frame_vsync = mvs_q;
    assign bus.matrix_frame_href  = href_q;
    assign bus.matrix_frame_clken = mclk_q;
    assign bus.matrix_row0        = row0_q;
    assign bus.matrix_row1        = row1_q;
    assign bus.matrix_row2        = row2_q;
    assign bus.matrix_x           = mx_q;
    assign bus.matrix_y           = my_q;
    assign bus.window_valid       = mclk_q & (my_q >= 11'd2);

`ifdef LINE_BUF_CTRL_LEN_CHECK_EN
    logic [10:0] strb_q, strb_d;
    logic        err_q, err_d;
    logic        strobe;

    // Counts every qualified strobe, including the ones dropped past the line length.
    always_comb begin
        strobe = bus.per_frame_clken & bus.per_frame_href & bus.per_frame_vsync & in_line;
        strb_d = strb_q;
        err_d  = err_q;
        if (vs_fall || frame_start || line_end) strb_d = '0;
        else if (strobe && (strb_q != 11'h7FF)) strb_d = strb_q + 11'd1;
        if (frame_start) err_d = 1'b0;
        else if (line_end && (strb_q != HDISP)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q <= '0;
            err_q  <= 1'b0;
        end else begin
            strb_q <= strb_d;
            err_q  <= err_d;
        end
    end

    assign bus.line_err = err_q;
`else
    assign bus.line_err = 1'b0;
`endif
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for the two-line shift-RAM buffer in the video processing chain. Sits between the camera/frame-timing source and the line shift RAM. It gates the RAM shift enable per accepted pixel, tracks column/row position, and presents a time-aligned three-row pixel column with its timing to the downstream 3x3 matrix/filter stage. It guarantees that every RAM shift corresponds to exactly one in-frame pixel, so line alignment survives malformed lines.

## Interface
- IMG_HDISP, 640, active pixels per line (1..2047)
- IMG_VDISP, 480, active lines per frame (1..2047)
- DATA_WIDTH, 8, pixel width
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- per_frame_vsync  in  1  frame valid, high for the whole frame
- per_frame_href  in  1  line valid, high for the whole line
- per_frame_clken  in  1  pixel strobe, qualified by href
- per_img_data  in  DATA_WIDTH  input pixel
- ram_clken  out  1  shift enable to the line shift RAM
- ram_shiftin  out  DATA_WIDTH  data into the RAM; equals per_img_data
- ram_taps0x  in  DATA_WIDTH  RAM tap, one line delayed
- ram_taps1x  in  DATA_WIDTH  RAM tap, two lines delayed
- matrix_frame_vsync / matrix_frame_href / matrix_frame_clken  out  1 each  aligned timing
- matrix_row0 / matrix_row1 / matrix_row2  out  DATA_WIDTH each  two lines above / one line above / current line
- matrix_x  out  11  column of the presented pixel
- matrix_y  out  11  row of the presented pixel
- window_valid  out  1  presented column has two real lines above (matrix_y >= 2)
- line_err  out  1  sticky line-length error (see Configuration)

## Operation
- States: IDLE, WAIT_LINE, ACTIVE, DONE.
- IDLE: on a vsync rising edge, clear x_cnt, y_cnt and line_err, then go to WAIT_LINE.
- WAIT_LINE: when href is high, go to ACTIVE.
- ACTIVE: on an href falling edge, clear x_cnt and increment y_cnt. If the new y_cnt == IMG_VDISP, go to DONE; otherwise go to WAIT_LINE.
- DONE: ignore all lines until vsync falls, then go to IDLE.
- vsync falling in any state: go to IDLE, clear counters, and drop ram_clken in the same cycle.
- Accepted pixel: per_frame_clken & per_frame_href & vsync & state in {WAIT_LINE, ACTIVE} & x_cnt < IMG_HDISP.
- ram_clken is combinational and equals the accepted-pixel signal. Excess pixels beyond IMG_HDISP are never shifted.
- x_cnt increments per accepted pixel and saturates at IMG_HDISP.
- Counters are 11 bits unsigned; no wrap is possible within the parameter range.
- Edge detection uses one registered copy each of vsync and href.

## Timing
- Latency is 1 cycle. On an accepted pixel in cycle N, cycle N+1 shows:
  - matrix_row2 = per_img_data, matrix_row1 = ram_taps0x, matrix_row0 = ram_taps1x, all sampled in cycle N
  - matrix_x = x_cnt(N), matrix_y = y_cnt(N)
  - matrix_frame_clken = 1
- matrix_frame_clken is low in every cycle with no accepted pixel in the previous cycle. Row and coordinate outputs hold their values in those cycles.
- matrix_frame_vsync and matrix_frame_href are per_frame_vsync and per_frame_href delayed 1 cycle.
- window_valid = matrix_frame_clken & (matrix_y >= 2).
- Reset value of every output is 0, except ram_shiftin, which follows per_img_data. Reset returns the FSM to IDLE asynchronously.
- Reset mid-frame: the block resumes only at the next vsync rising edge.

## Configuration
- LINE_BUF_CTRL_LEN_CHECK_EN defined:
  - At each href falling edge in ACTIVE, compare the count of strobes seen on that line (including excess strobes, counted to saturation at 2047) against IMG_HDISP.
  - On a mismatch, set line_err; it stays set until the next vsync rising edge or reset.
- Macro undefined: line_err is tied to 0 and no strobe counter is built.

## Test plan
- Frame IMG_HDISP=4, IMG_VDISP=3, pixel value = 16*y+x, continuous clken -> 12 ram_clken pulses. Line y=2, x=1 presents row2=0x21, row1=0x11, row0=0x01; window_valid is high only on line 2.
- Line with 6 strobes at IMG_HDISP=4 -> only 4 ram_clken pulses. Next line still aligns. line_err=1 with the macro, 0 without.
- Line with 3 strobes at IMG_HDISP=4 -> x_cnt clears at href fall and y increments. line_err=1 with the macro.
- clken toggling every other cycle -> matrix_frame_clken mirrors the pattern delayed 1 cycle, and row outputs hold between strobes.
- Fourth line sent at IMG_VDISP=3 -> no ram_clken pulses; FSM stays in DONE until vsync falls.
- rst_n asserted mid-line, then deasserted while vsync is still high -> all outputs are 0 and there is no ram_clken until the next vsync rising edge. The next frame processes normally.
